muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, the next-generation arithmetic block beside the datapath ALU. It executes MIPS MULT/MULTU/DIV/DIVU over a parametrised operand width using a start/busy/done handshake and fixed latency. It also services MTHI/MTLO writes. The datapath stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Datapath-facing bundle of the iterative multiply/divide unit: operation request,
// MTHI/MTLO writes and the architectural HI/LO results.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers, one result bit per cycle.
// Define MULDIV_DIV_EN to build the divider; without it divide requests are ignored.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic signed [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;

    logic               start_acc;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   hi_res;
    logic [WIDTH-1:0]   lo_res;

`ifdef MULDIV_DIV_EN
    logic               is_div;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   a_orig;
    logic               dbz_r;
    logic               dbz_res;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;

    assign start_acc = (state == IDLE) && bus.start;
`else
    assign start_acc = (state == IDLE) && bus.start && !bus.op[1];
`endif

    // Signed ops run on magnitudes; op[0] selects the signed variant.
    assign a_mag = abs_w(bus.a, bus.op[0]);
    assign b_mag = abs_w(bus.b, bus.op[0]);

    // Iteration step: multiply adds into the upper half then shifts right;
    // divide shifts the remainder left and keeps the subtraction if it fits.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div) begin
            if (div_diff[WIDTH])
                acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
`endif
    end

    // Sign fix-up applied in FIN.
    always_comb begin
        prod   = neg_2w(acc, neg_res);
        hi_res = prod[2*WIDTH-1:WIDTH];
        lo_res = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        dbz_res = 1'b0;
        if (is_div) begin
            if (b_zero) begin
                hi_res  = a_orig;
                lo_res  = '1;
                dbz_res = 1'b1;
            end else begin
                hi_res = neg_w(acc[2*WIDTH-1:WIDTH], neg_rem);
                lo_res = neg_w(acc[WIDTH-1:0], neg_res);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
`ifdef MULDIV_DIV_EN
            dbz_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef MULDIV_DIV_EN
            dbz_r  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        if (bus.hi_we) hi_r <= bus.wdata;
                        if (bus.lo_we) lo_r <= bus.wdata;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIN;
                end
                FIN: begin
                    hi_r   <= hi_res;
                    lo_r   <= lo_res;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
`ifdef MULDIV_DIV_EN
                    dbz_r  <= dbz_res;
`endif
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Operand/accumulator datapath carries no reset; it is always reloaded on start.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            neg_res <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            is_div  <= bus.op[1];
            neg_rem <= bus.op[0] & bus.a[WIDTH-1];
            b_zero  <= (bus.b == '0);
            a_orig  <= bus.a;
            opnd    <= bus.op[1] ? b_mag : a_mag;
            acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
`else
            opnd    <= a_mag;
            acc     <= {{WIDTH{1'b0}}, b_mag};
`endif
        end else if (state == RUN) begin
            acc <= acc_next;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
`ifdef MULDIV_DIV_EN
    assign bus.dbz  = dbz_r;
`else
    assign bus.dbz  = 1'b0;
`endif
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): directed vectors, expected results
// queued at issue and compared by a monitor whenever done pulses.
module tb_muldiv_unit;
    localparam int W = 32;

    typedef struct {
        string      name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic       dbz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
                check({e.name, "_dbz"}, 64'(bus.dbz), 64'(e.dbz));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; lat counts negedges before it.
    task automatic wait_done(input string name, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
            if (bus.busy === 1'b1) bcnt++;
            lat++;
            if (lat > 200) begin
                check({name, "_timeout"}, 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edbz);
        exp_t e;
        int lat, bcnt;
        e.name = name; e.hi = ehi; e.lo = elo; e.dbz = edbz;
        q.push_back(e);
        issue(op, a, b);
        wait_done(name, lat, bcnt);
        check({name, "_latency"}, 64'(lat), 64'(W + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, seen;
        exp_t e;
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dbz",  64'(bus.dbz),  64'd0);
        check("rst_hi",   64'(bus.hi),   64'd0);
        check("rst_lo",   64'(bus.lo),   64'd0);

        // MULTU max x max with latency, busy length and single-cycle done.
        e.name = "multu_max"; e.hi = 32'hFFFF_FFFE; e.lo = 32'h0000_0001; e.dbz = 1'b0;
        q.push_back(e);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", lat, bcnt);
        check("multu_max_latency", 64'(lat), 64'd33);
        check("multu_max_busy_cycles", 64'(bcnt), 64'd33);
        check("multu_max_busy_at_done", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("multu_max_done_pulse", 64'(bus.done), 64'd0);

        // Back-to-back chain: each start lands in the cycle done is high.
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
`ifdef MULDIV_DIV_EN
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_dbz", 2'b10, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("div_dbz_neg", 2'b11, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);
`else
        @(negedge clk);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) seen++;
        end
        check("nodiv_ignored", 64'(seen), 64'd0);
        check("nodiv_hi_held", 64'(bus.hi), 64'hFFFF_FFFF);
        check("nodiv_lo_held", 64'(bus.lo), 64'hFFFF_FFF1);
        run_op("mult_2_m2", 2'b01, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0);
`endif

        // MTHI and MTLO together.
        @(negedge clk);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        @(negedge clk);
        check("mt_both_hi", 64'(bus.hi), 64'hA5A5_A5A5);
        check("mt_both_lo", 64'(bus.lo), 64'hA5A5_A5A5);

        // Start and MT write pulsed mid-RUN are ignored; HI/LO hold meanwhile.
        e.name = "multu_6_7"; e.hi = 32'd0; e.lo = 32'd42; e.dbz = 1'b0;
        q.push_back(e);
        issue(2'b00, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd9; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.wdata = 32'h55;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.hi_we = 1'b0;
        @(negedge clk);
        check("run_hi_held", 64'(bus.hi), 64'hA5A5_A5A5);
        check("run_lo_held", 64'(bus.lo), 64'hA5A5_A5A5);
        wait_done("multu_6_7", lat, bcnt);
        check("multu_6_7_latency", 64'(lat + 6), 64'd33);
        @(negedge clk);
        check("after_ignored_busy", 64'(bus.busy), 64'd0);

        bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk);
        #1 bus.lo_we = 1'b0;
        @(negedge clk);
        check("mtlo_lo", 64'(bus.lo), 64'h1234);
        check("mtlo_hi_kept", 64'(bus.hi), 64'd0);

        // Reset during RUN aborts without a done pulse.
        issue(2'b00, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hi",   64'(bus.hi),   64'd0);
        check("abort_lo",   64'(bus.lo),   64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run_op("multu_3_3", 2'b00, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
